// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared LSU op/size encodings and memory-stage FSM states
package riscv_pkg;

  localparam int TAG_WIDTH_DEF = 4;

  typedef enum logic {
    LSU_OP_LD = 1'b0,
    LSU_OP_WR = 1'b1
  } lsu_op_e;

  typedef enum logic [1:0] {
    LSU_B = 2'd0,
    LSU_H = 2'd1,
    LSU_W = 2'd2
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } mem_state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte enables, store data replication and load data shift/extend
module lsu_align
  import riscv_pkg::*;
(
  input  lsu_size_e   size,
  input  logic [1:0]  offset,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [1:0]  off;
  logic [31:0] shifted;

  // Offset is forced to the access size's natural alignment before use.
  always_comb begin
    off       = 2'b00;
    be        = 4'hF;
    wdata_rep = wdata;
    rdata_ext = 32'h0;
    case (size)
      LSU_B: begin
        off       = offset;
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      LSU_H: begin
        off       = {offset[1], 1'b0};
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        off       = 2'b00;
        be        = 4'hF;
        wdata_rep = wdata;
      end
    endcase
    shifted = rdata >> {off, 3'b000};
    case (size)
      LSU_B:   rdata_ext = {{24{sext & shifted[7]}}, shifted[7:0]};
      LSU_H:   rdata_ext = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX->WB memory stage with data-bus FSM; LSU_MISALIGN_EXC_EN enables misalign errors
module mem_stage
  import riscv_pkg::*;
#(
  parameter int TAG_WIDTH = TAG_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_ex,
  output logic                 ready_mem,
  input  logic [31:0]          pc_ex,
  input  logic                 rd_wr_en_ex,
  input  logic [TAG_WIDTH-1:0] rd_wr_tag_ex,
  input  logic [4:0]           rd_wr_addr_ex,
  input  logic [31:0]          rd_wr_data_ex,
  input  logic                 lsu_en_ex,
  input  lsu_op_e              lsu_op_ex,
  input  lsu_size_e            lsu_size_ex,
  input  logic                 lsu_sext_ex,
  input  logic [31:0]          lsu_addr_ex,
  input  logic [31:0]          lsu_wdata_ex,
  input  logic                 exc_taken_ex,
  input  logic                 flush_M,
  output logic                 data_req,
  output logic                 data_we,
  output logic [3:0]           data_be,
  output logic [31:0]          data_addr,
  output logic [31:0]          data_wdata,
  input  logic                 data_gnt,
  input  logic                 data_rvalid,
  input  logic                 data_err,
  input  logic [31:0]          data_rdata,
  output logic [31:0]          pc_wb,
  output logic                 rd_wr_en_wb,
  output logic [TAG_WIDTH-1:0] rd_wr_tag_wb,
  output logic [4:0]           rd_wr_addr_wb,
  output logic [31:0]          rd_wr_data_wb,
  output logic                 lsu_en_wb,
  output lsu_op_e              lsu_op_wb,
  output logic [31:0]          lsu_rdata_wb,
  output logic                 lsu_valid_wb,
  output logic                 lsu_err_wb,
  output logic                 exc_taken_wb,
  input  logic                 ready_wb
);

  mem_state_e  state;
  logic        valid_q;
  logic        skip_q;
  logic        misalign_q;
  lsu_size_e   lsu_size_q;
  logic        lsu_sext_q;
  logic [31:0] lsu_addr_q;
  logic [31:0] lsu_wdata_q;
  logic [31:0] rdata_ext;
  logic        misalign_ex;
  logic        accept;

`ifdef LSU_MISALIGN_EXC_EN
  assign misalign_ex = (lsu_size_ex == LSU_H) ? lsu_addr_ex[0] :
                       (lsu_size_ex == LSU_W) ? |lsu_addr_ex[1:0] : 1'b0;
`else
  assign misalign_ex = 1'b0;
`endif

  assign ready_mem  = (~valid_q | ready_wb) & (state == IDLE);
  assign accept     = valid_ex & ready_mem & ~flush_M;
  // Excepted or misaligned accesses pass through REQ for one cycle without touching the bus.
  assign data_req   = (state == REQ) & ~skip_q;
  assign data_we    = (lsu_op_wb == LSU_OP_WR);
  assign data_addr  = {lsu_addr_q[31:2], 2'b00};

  lsu_align u_align (
    .size      (lsu_size_q),
    .offset    (lsu_addr_q[1:0]),
    .sext      (lsu_sext_q),
    .wdata     (lsu_wdata_q),
    .rdata     (data_rdata),
    .be        (data_be),
    .wdata_rep (data_wdata),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      valid_q       <= 1'b0;
      skip_q        <= 1'b0;
      misalign_q    <= 1'b0;
      lsu_size_q    <= LSU_B;
      lsu_sext_q    <= 1'b0;
      lsu_addr_q    <= 32'h0;
      lsu_wdata_q   <= 32'h0;
      pc_wb         <= 32'h0;
      rd_wr_en_wb   <= 1'b0;
      rd_wr_tag_wb  <= '0;
      rd_wr_addr_wb <= 5'h0;
      rd_wr_data_wb <= 32'h0;
      lsu_en_wb     <= 1'b0;
      lsu_op_wb     <= LSU_OP_LD;
      lsu_rdata_wb  <= 32'h0;
      lsu_valid_wb  <= 1'b0;
      lsu_err_wb    <= 1'b0;
      exc_taken_wb  <= 1'b0;
    end else begin
      // Flush or WB consumption removes the held instruction and its WB flags.
      if (flush_M && state != DRAIN || state == IDLE && !accept && ready_wb) begin
        valid_q      <= 1'b0;
        rd_wr_en_wb  <= 1'b0;
        lsu_en_wb    <= 1'b0;
        lsu_valid_wb <= 1'b0;
        lsu_err_wb   <= 1'b0;
        exc_taken_wb <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            valid_q       <= 1'b1;
            pc_wb         <= pc_ex;
            rd_wr_en_wb   <= rd_wr_en_ex;
            rd_wr_tag_wb  <= rd_wr_tag_ex;
            rd_wr_addr_wb <= rd_wr_addr_ex;
            rd_wr_data_wb <= rd_wr_data_ex;
            lsu_en_wb     <= lsu_en_ex;
            lsu_op_wb     <= lsu_op_ex;
            lsu_size_q    <= lsu_size_ex;
            lsu_sext_q    <= lsu_sext_ex;
            lsu_addr_q    <= lsu_addr_ex;
            lsu_wdata_q   <= lsu_wdata_ex;
            exc_taken_wb  <= exc_taken_ex;
            skip_q        <= exc_taken_ex | misalign_ex;
            misalign_q    <= misalign_ex & ~exc_taken_ex;
            lsu_rdata_wb  <= 32'h0;
            lsu_valid_wb  <= 1'b0;
            lsu_err_wb    <= 1'b0;
            if (lsu_en_ex) state <= REQ;
          end
        end
        REQ: begin
          if (flush_M) begin
            state <= (data_gnt && !skip_q) ? DRAIN : IDLE;
          end else if (skip_q) begin
            state        <= IDLE;
            lsu_valid_wb <= 1'b1;
            lsu_err_wb   <= misalign_q;
          end else if (data_gnt) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (flush_M) begin
            state <= data_rvalid ? IDLE : DRAIN;
          end else if (data_rvalid) begin
            state        <= IDLE;
            lsu_valid_wb <= 1'b1;
            lsu_err_wb   <= data_err;
            lsu_rdata_wb <= (lsu_op_wb == LSU_OP_LD) ? rdata_ext : 32'h0;
          end
        end
        DRAIN: begin
          if (data_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_ex, ready_mem;
  logic [31:0] pc_ex;
  logic        rd_wr_en_ex;
  logic [3:0]  rd_wr_tag_ex;
  logic [4:0]  rd_wr_addr_ex;
  logic [31:0] rd_wr_data_ex;
  logic        lsu_en_ex;
  lsu_op_e     lsu_op_ex;
  lsu_size_e   lsu_size_ex;
  logic        lsu_sext_ex;
  logic [31:0] lsu_addr_ex, lsu_wdata_ex;
  logic        exc_taken_ex, flush_M;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic [31:0] pc_wb;
  logic        rd_wr_en_wb;
  logic [3:0]  rd_wr_tag_wb;
  logic [4:0]  rd_wr_addr_wb;
  logic [31:0] rd_wr_data_wb;
  logic        lsu_en_wb;
  lsu_op_e     lsu_op_wb;
  logic [31:0] lsu_rdata_wb;
  logic        lsu_valid_wb, lsu_err_wb, exc_taken_wb;
  logic        ready_wb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage #(.TAG_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .valid_ex(valid_ex), .ready_mem(ready_mem),
    .pc_ex(pc_ex), .rd_wr_en_ex(rd_wr_en_ex), .rd_wr_tag_ex(rd_wr_tag_ex),
    .rd_wr_addr_ex(rd_wr_addr_ex), .rd_wr_data_ex(rd_wr_data_ex),
    .lsu_en_ex(lsu_en_ex), .lsu_op_ex(lsu_op_ex), .lsu_size_ex(lsu_size_ex),
    .lsu_sext_ex(lsu_sext_ex), .lsu_addr_ex(lsu_addr_ex), .lsu_wdata_ex(lsu_wdata_ex),
    .exc_taken_ex(exc_taken_ex), .flush_M(flush_M),
    .data_req(data_req), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_err(data_err),
    .data_rdata(data_rdata),
    .pc_wb(pc_wb), .rd_wr_en_wb(rd_wr_en_wb), .rd_wr_tag_wb(rd_wr_tag_wb),
    .rd_wr_addr_wb(rd_wr_addr_wb), .rd_wr_data_wb(rd_wr_data_wb),
    .lsu_en_wb(lsu_en_wb), .lsu_op_wb(lsu_op_wb), .lsu_rdata_wb(lsu_rdata_wb),
    .lsu_valid_wb(lsu_valid_wb), .lsu_err_wb(lsu_err_wb),
    .exc_taken_wb(exc_taken_wb), .ready_wb(ready_wb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present one instruction for a single accept edge; returns at the next negedge.
  task automatic issue(input logic lsu, input lsu_op_e op, input lsu_size_e sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] wd,
                       input logic exc);
    valid_ex     = 1'b1;
    lsu_en_ex    = lsu;
    lsu_op_ex    = op;
    lsu_size_ex  = sz;
    lsu_sext_ex  = sx;
    lsu_addr_ex  = a;
    lsu_wdata_ex = wd;
    exc_taken_ex = exc;
    pc_ex        = a + 32'h1000;
    step();
    valid_ex     = 1'b0;
    lsu_en_ex    = 1'b0;
    exc_taken_ex = 1'b0;
  endtask

  // Grant now, return read data one cycle after; completion is visible on return.
  task automatic respond(input logic [31:0] rd, input logic err);
    data_gnt = 1'b1;
    step();
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = rd;
    data_err    = err;
    step();
    data_rvalid = 1'b0;
    data_err    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_ex = 0; pc_ex = 0; rd_wr_en_ex = 0; rd_wr_tag_ex = 0;
    rd_wr_addr_ex = 0; rd_wr_data_ex = 0; lsu_en_ex = 0; lsu_op_ex = LSU_OP_LD;
    lsu_size_ex = LSU_W; lsu_sext_ex = 0; lsu_addr_ex = 0; lsu_wdata_ex = 0;
    exc_taken_ex = 0; flush_M = 0; data_gnt = 0; data_rvalid = 0; data_err = 0;
    data_rdata = 0; ready_wb = 1'b1;
    step(); step();
    chk("rst_ready_mem", {31'h0, ready_mem}, 32'h1);
    chk("rst_data_req", {31'h0, data_req}, 32'h0);
    chk("rst_lsu_valid", {31'h0, lsu_valid_wb}, 32'h0);
    chk("rst_rd_wr_en", {31'h0, rd_wr_en_wb}, 32'h0);
    chk("rst_pc_wb", pc_wb, 32'h0);
    reset = 1'b0;
    step();

    // Non-LSU pass-through, then WB stall and bubble
    rd_wr_en_ex = 1'b1; rd_wr_tag_ex = 4'h5; rd_wr_addr_ex = 5'd7; rd_wr_data_ex = 32'hCAFE0001;
    ready_wb = 1'b0;
    issue(1'b0, LSU_OP_LD, LSU_W, 1'b0, 32'h40, 32'h0, 1'b0);
    rd_wr_en_ex = 1'b0;
    chk("alu_rd_en", {31'h0, rd_wr_en_wb}, 32'h1);
    chk("alu_rd_data", rd_wr_data_wb, 32'hCAFE0001);
    chk("alu_rd_tag", {28'h0, rd_wr_tag_wb}, 32'h5);
    chk("alu_pc", pc_wb, 32'h1040);
    chk("alu_stall_ready", {31'h0, ready_mem}, 32'h0);
    step();
    chk("alu_stall_hold", {31'h0, rd_wr_en_wb}, 32'h1);
    ready_wb = 1'b1;
    step();
    chk("alu_bubble", {31'h0, rd_wr_en_wb}, 32'h0);
    chk("alu_bubble_ready", {31'h0, ready_mem}, 32'h1);

    // 1: LW 0x100
    issue(1'b1, LSU_OP_LD, LSU_W, 1'b0, 32'h100, 32'h0, 1'b0);
    chk("lw_req", {31'h0, data_req}, 32'h1);
    chk("lw_be", {28'h0, data_be}, 32'hF);
    chk("lw_addr", data_addr, 32'h100);
    chk("lw_we", {31'h0, data_we}, 32'h0);
    chk("lw_ready_busy", {31'h0, ready_mem}, 32'h0);
    respond(32'hDEADBEEF, 1'b0);
    chk("lw_valid", {31'h0, lsu_valid_wb}, 32'h1);
    chk("lw_rdata", lsu_rdata_wb, 32'hDEADBEEF);
    chk("lw_err", {31'h0, lsu_err_wb}, 32'h0);
    chk("lw_req_done", {31'h0, data_req}, 32'h0);
    step();
    chk("lw_valid_clear", {31'h0, lsu_valid_wb}, 32'h0);

    // 2: LB / LBU at 0x103
    issue(1'b1, LSU_OP_LD, LSU_B, 1'b1, 32'h103, 32'h0, 1'b0);
    chk("lb_be", {28'h0, data_be}, 32'h8);
    chk("lb_addr", data_addr, 32'h100);
    respond(32'h80112233, 1'b0);
    chk("lb_rdata", lsu_rdata_wb, 32'hFFFFFF80);
    issue(1'b1, LSU_OP_LD, LSU_B, 1'b0, 32'h103, 32'h0, 1'b0);
    respond(32'h80112233, 1'b0);
    chk("lbu_rdata", lsu_rdata_wb, 32'h00000080);
    issue(1'b1, LSU_OP_LD, LSU_H, 1'b1, 32'h102, 32'h0, 1'b0);
    respond(32'h80112233, 1'b0);
    chk("lh_rdata", lsu_rdata_wb, 32'hFFFF8011);

    // 3: SH 0x102
    issue(1'b1, LSU_OP_WR, LSU_H, 1'b0, 32'h102, 32'h00001234, 1'b0);
    chk("sh_be", {28'h0, data_be}, 32'hC);
    chk("sh_wdata", data_wdata, 32'h12341234);
    chk("sh_we", {31'h0, data_we}, 32'h1);
    respond(32'hFFFFFFFF, 1'b0);
    chk("sh_valid", {31'h0, lsu_valid_wb}, 32'h1);
    chk("sh_rdata", lsu_rdata_wb, 32'h0);

    // 4: request held without grant, then error response
    issue(1'b1, LSU_OP_LD, LSU_W, 1'b0, 32'h204, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_req", {31'h0, data_req}, 32'h1);
      chk("hold_addr", data_addr, 32'h204);
      chk("hold_be", {28'h0, data_be}, 32'hF);
      chk("hold_ready", {31'h0, ready_mem}, 32'h0);
      step();
    end
    respond(32'h0, 1'b1);
    chk("err_valid", {31'h0, lsu_valid_wb}, 32'h1);
    chk("err_err", {31'h0, lsu_err_wb}, 32'h1);

    // 5: flush while waiting for rvalid
    issue(1'b1, LSU_OP_LD, LSU_W, 1'b0, 32'h300, 32'h0, 1'b0);
    data_gnt = 1'b1;
    step();
    data_gnt = 1'b0;
    flush_M = 1'b1;
    step();
    flush_M = 1'b0;
    chk("drain_ready0", {31'h0, ready_mem}, 32'h0);
    chk("drain_rd_en", {31'h0, rd_wr_en_wb}, 32'h0);
    step();
    chk("drain_ready1", {31'h0, ready_mem}, 32'h0);
    data_rvalid = 1'b1; data_rdata = 32'h55555555;
    step();
    data_rvalid = 1'b0;
    chk("drain_no_valid", {31'h0, lsu_valid_wb}, 32'h0);
    chk("drain_ready_back", {31'h0, ready_mem}, 32'h1);

    // Upstream exception: no bus request, completes next cycle without error
    issue(1'b1, LSU_OP_LD, LSU_W, 1'b0, 32'h400, 32'h0, 1'b1);
    chk("exc_no_req", {31'h0, data_req}, 32'h0);
    step();
    chk("exc_valid", {31'h0, lsu_valid_wb}, 32'h1);
    chk("exc_err", {31'h0, lsu_err_wb}, 32'h0);
    chk("exc_taken", {31'h0, exc_taken_wb}, 32'h1);

    // 6: misaligned LW 0x102
    issue(1'b1, LSU_OP_LD, LSU_W, 1'b0, 32'h102, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_EXC_EN
    chk("mis_no_req", {31'h0, data_req}, 32'h0);
    step();
    chk("mis_valid", {31'h0, lsu_valid_wb}, 32'h1);
    chk("mis_err", {31'h0, lsu_err_wb}, 32'h1);
`else
    chk("mis_req", {31'h0, data_req}, 32'h1);
    chk("mis_addr", data_addr, 32'h100);
    chk("mis_be", {28'h0, data_be}, 32'hF);
    respond(32'h11223344, 1'b0);
    chk("mis_rdata", lsu_rdata_wb, 32'h11223344);
`endif
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
